pio_edge_debounce_in: RTL and testbench

//  Parametrised Avalon-MM input port for panel buttons and coin sensors. Each of

---
 rtl/pio_in_pkg.sv | 22 ++
 rtl/pio_debounce_ch.sv | 63 ++++++
 rtl/pio_edge_debounce_in.sv | 109 ++++++++++
 tb/tb_pio_edge_debounce_in.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_in_pkg.sv
// Shared definitions for the debounced edge-capture input port: register word
// addresses and the debounce counter sizing helper.
package pio_in_pkg;

    localparam int unsigned ADDR_DATA    = 0;
    localparam int unsigned ADDR_RAW     = 1;
    localparam int unsigned ADDR_IRQMASK = 2;
    localparam int unsigned ADDR_CAPTURE = 3;
    localparam int unsigned ADDR_RISE_EN = 4;
    localparam int unsigned ADDR_FALL_EN = 5;

    // Counter must be able to hold DEBOUNCE_CYCLES; never narrower than one bit.
    function automatic int unsigned clog2_cnt(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: 2-flop synchroniser, hold-time debounce filter and
// single-cycle rise/fall pulses derived from the accepted level.
module pio_debounce_ch
    import pio_in_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic raw_o,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = clog2_cnt(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             stable_prev_q;

    // The count only advances while the synchronised level disagrees with the
    // accepted one; any return to the accepted level restarts it from zero.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q        <= 1'b0;
            sync_q        <= 1'b0;
            cnt_q         <= '0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
        end else begin
            meta_q        <= in_i;
            sync_q        <= meta_q;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
        end
    end

    assign raw_o    = sync_q;
    assign stable_o = stable_q;
    assign rise_o   = stable_q & ~stable_prev_q;
    assign fall_o   = ~stable_q & stable_prev_q;

endmodule

// File: rtl/pio_edge_debounce_in.sv
// Avalon-MM input port with per-channel debounce, per-bit edge selection,
// sticky W1C capture bits and a masked level interrupt.
module pio_edge_debounce_in
    import pio_in_pkg::*;
#(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned ADDR_W          = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [WIDTH-1:0]  writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  readdata,
    output logic              irq
);

    logic [WIDTH-1:0] raw_w;
    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pio_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .in_i    (in_port[i]),
            .raw_o   (raw_w[i]),
            .stable_o(stable_w[i]),
            .rise_o  (rise_w[i]),
            .fall_o  (fall_w[i])
        );
    end

    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] rise_en_q,  rise_en_d;
    logic [WIDTH-1:0] fall_en_q,  fall_en_d;
    logic [WIDTH-1:0] cap_q,      cap_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;

    logic             wr;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;

    assign wr = chipselect & ~write_n;
    assign ev = (rise_w & rise_en_q) | (fall_w & fall_en_q);

    always_comb begin
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        clr        = '0;
        if (wr) begin
            if (address == ADDR_W'(ADDR_IRQMASK)) begin
                irq_mask_d = writedata;
            end
            if (address == ADDR_W'(ADDR_RISE_EN)) begin
                rise_en_d = writedata;
            end
            if (address == ADDR_W'(ADDR_FALL_EN)) begin
                fall_en_d = writedata;
            end
            if (address == ADDR_W'(ADDR_CAPTURE)) begin
                clr = writedata;
            end
        end
        // OR-ing the event in last lets a fresh edge survive a same-cycle clear.
        cap_d = (cap_q & ~clr) | ev;
    end

    // Read mux samples the pre-write register contents every cycle.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_W'(ADDR_DATA):    readdata_d = stable_w;
            ADDR_W'(ADDR_RAW):     readdata_d = raw_w;
            ADDR_W'(ADDR_IRQMASK): readdata_d = irq_mask_q;
            ADDR_W'(ADDR_CAPTURE): readdata_d = cap_q;
            ADDR_W'(ADDR_RISE_EN): readdata_d = rise_en_q;
            ADDR_W'(ADDR_FALL_EN): readdata_d = fall_en_q;
            default:               readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_edge_debounce_in.sv
// Directed and randomized bench for pio_edge_debounce_in, checked against a
// window-based behavioural model of debounce, edge capture and register reads.
module tb_pio_edge_debounce_in;

    localparam int W  = 3;
    localparam int D  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [W-1:0]  writedata;
    logic [W-1:0]  in_port;
    logic [W-1:0]  readdata;
    logic          irq;

    always #5 clk = ~clk;

    pio_edge_debounce_in #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .ADDR_W(AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the last D synchronised samples decide acceptance of a new level.
    logic [W-1:0] m_pipe1, m_pipe2, m_stable, m_prev;
    logic [W-1:0] m_mask, m_rise, m_fall, m_cap, m_rd;
    logic [W-1:0] m_win[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_read(input logic [AW-1:0] a);
        case (a)
            3'd0:    return m_stable;
            3'd1:    return m_pipe2;
            3'd2:    return m_mask;
            3'd3:    return m_cap;
            3'd4:    return m_rise;
            3'd5:    return m_fall;
            default: return '0;
        endcase
    endfunction

    task automatic model_edge();
        logic [W-1:0] nstable, ev, clr;
        bit same;
        if (!reset_n) begin
            m_pipe1 = '0; m_pipe2 = '0; m_stable = '0; m_prev = '0;
            m_mask = '0; m_rise = '0; m_fall = '0; m_cap = '0; m_rd = '0;
            m_win.delete();
            return;
        end
        m_win.push_back(m_pipe2);
        if (m_win.size() > D) void'(m_win.pop_front());
        nstable = m_stable;
        if (m_win.size() == D) begin
            for (int b = 0; b < W; b++) begin
                same = 1'b1;
                for (int k = 1; k < D; k++) begin
                    if (m_win[k][b] != m_win[0][b]) same = 1'b0;
                end
                if (same && (m_win[0][b] != m_stable[b])) nstable[b] = m_win[0][b];
            end
        end
        ev  = (m_stable & ~m_prev & m_rise) | (~m_stable & m_prev & m_fall);
        clr = (chipselect && !write_n && address == 3'd3) ? writedata : '0;
        m_rd  = m_read(address);
        m_cap = (m_cap & ~clr) | ev;
        if (chipselect && !write_n) begin
            if (address == 3'd2) m_mask = writedata;
            if (address == 3'd4) m_rise = writedata;
            if (address == 3'd5) m_fall = writedata;
        end
        m_prev   = m_stable;
        m_stable = nstable;
        m_pipe2  = m_pipe1;
        m_pipe1  = in_port;
    endtask

    // One clock: drive bus, advance model, compare readdata and irq every cycle.
    task automatic cycle(input logic [AW-1:0] a, input logic cs, input logic wn,
                         input logic [W-1:0] wd);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        @(posedge clk);
        model_edge();
        #1;
        chk("cyc_readdata", readdata, m_rd);
        chk("cyc_irq", irq, |(m_cap & m_mask));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(3'd0, 1'b0, 1'b1, '0);
    endtask

    task automatic wr_reg(input logic [AW-1:0] a, input logic [W-1:0] d);
        cycle(a, 1'b1, 1'b0, d);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cycle(a, 1'b0, 1'b1, '0);
    endtask

    logic [W-1:0] exp_map[8];

    initial begin
        reset_n = 1'b0; in_port = 3'b111;
        address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;

        // Reset with inputs already high.
        idle(2);
        chk("rst_readdata", readdata, 0);
        chk("rst_irq", irq, 0);
        reset_n = 1'b1;
        idle(6);
        idle(1);  // registered read shows the level accepted at clock 6
        chk("data_after_reset", readdata, 3'b111);
        rd(3'd3);
        chk("cap_no_rise_en", readdata, 0);

        // Rise capture on bit 0.
        in_port = 3'b000;
        idle(8);
        wr_reg(3'd4, 3'b001);
        wr_reg(3'd2, 3'b001);
        in_port[0] = 1'b1;
        idle(10);
        in_port[0] = 1'b0;
        idle(2);
        chk("rise_irq", irq, 1);
        rd(3'd3);
        chk("rise_cap", readdata, 3'b001);
        wr_reg(3'd3, 3'b001);
        chk("w1c_irq", irq, 0);
        rd(3'd3);
        chk("w1c_cap", readdata, 0);

        // Glitch rejection then exact acceptance latency on bit 1.
        idle(6);
        in_port[1] = 1'b1;
        idle(3);
        in_port[1] = 1'b0;
        idle(8);
        chk("glitch_data", readdata, 0);
        rd(3'd3);
        chk("glitch_cap", readdata, 0);
        in_port[1] = 1'b1;
        idle(6);
        chk("deb_before", readdata[1], 0);
        idle(1);
        chk("deb_after", readdata[1], 1);

        // Any-edge capture on bit 2, cleared between edges.
        wr_reg(3'd5, 3'b100);
        wr_reg(3'd4, 3'b100);
        wr_reg(3'd2, 3'b100);
        in_port[2] = 1'b1;
        idle(8);
        chk("any_rise_irq", irq, 1);
        rd(3'd3);
        chk("any_rise_cap", readdata, 3'b100);
        wr_reg(3'd3, 3'b100);
        rd(3'd3);
        chk("any_clr_cap", readdata, 0);
        in_port[2] = 1'b0;
        idle(8);
        rd(3'd3);
        chk("any_fall_cap", readdata, 3'b100);
        chk("any_fall_irq", irq, 1);
        wr_reg(3'd3, 3'b111);

        // W1C in the same cycle the rise event lands.
        wr_reg(3'd4, 3'b001);
        in_port[0] = 1'b1;
        idle(6);
        wr_reg(3'd3, 3'b001);
        rd(3'd3);
        chk("collide_cap", readdata, 3'b001);

        // Read mux over all addresses, chipselect low.
        wr_reg(3'd2, 3'b101);
        wr_reg(3'd4, 3'b011);
        wr_reg(3'd5, 3'b110);
        wr_reg(3'd3, 3'b111);
        wr_reg(3'd6, 3'b111);
        wr_reg(3'd7, 3'b111);
        idle(4);
        exp_map = '{3'b011, 3'b011, 3'b101, 3'b000, 3'b011, 3'b110, 3'b000, 3'b000};
        for (int a = 0; a < 8; a++) begin
            rd(AW'(a));
            chk($sformatf("map_addr%0d", a), readdata, exp_map[a]);
        end

        // Randomized traffic against the model, with one mid-run reset.
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
            end
            reset_n = (c != 400);
            if ($urandom_range(0, 3) == 0) begin
                wr_reg(AW'($urandom_range(0, 7)), W'($urandom));
            end else begin
                rd(AW'($urandom_range(0, 7)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
